rom_burst_reader: RTL and testbench
===================================

Name: rom_burst_reader

Overview:
Parametrised successor to the team's case-table lookup ROM. It uses a registered, synchronous lookup with a formula-defined table, and has a built-in burst address generator. A request supplies a base address and a length; the block then streams consecutive table words out over a valid/ready interface. It sits between a controller that issues table-read requests and a downstream consumer that may stall.

Parameters:
- ADDR_WIDTH, 8, address width; address space is 2^ADDR_WIDTH.
- DATA_WIDTH, 8, width of each table word.
- TABLE_LEN, 32, number of populated entries (1..2^ADDR_WIDTH).
- INIT_TOP, 32, value of entry 0; entries count down from it.
- FILL_VALUE, 0, value returned for unpopulated addresses (never X).
- LEN_WIDTH, 8, width of burst_len.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- resetn, input, 1, asynchronous active-low reset.
- start, input, 1, burst request; sampled only in IDLE.
- base_addr, input, ADDR_WIDTH, first address of the burst; sampled with start.
- burst_len, input, LEN_WIDTH, number of words in the burst; sampled with start.
- busy, output, 1, high while in RUN.
- done, output, 1, one-cycle pulse when a burst completes.
- rd_data, output, DATA_WIDTH, output word.
- rd_oor, output, 1, high when the word in rd_data came from an address >= TABLE_LEN.
- rd_valid, output, 1, rd_data and rd_oor are valid.
- rd_ready, input, 1, consumer accepts the word.

Behaviour:
- Table function: f(a) = (INIT_TOP - a) mod 2^DATA_WIDTH when a < TABLE_LEN, else FILL_VALUE. With defaults, f(0)=32, f(31)=1, f(32..255)=0.
- Reset (resetn low, asynchronous): state=IDLE; busy=0, done=0, rd_valid=0, rd_data=0, rd_oor=0; internal address and remaining count = 0.
- FSM has two states, IDLE and RUN.
- IDLE:
  - start=1 with burst_len!=0: latch addr_cnt=base_addr and remaining=burst_len; go to RUN; busy=1 from the next cycle.
  - start=1 with burst_len=0: stay IDLE; done=1 for exactly one cycle on the next cycle; no data is produced.
- RUN load condition: load = (remaining!=0) && (!rd_valid || rd_ready).
- On each load:
  - rd_data<=f(addr_cnt), rd_oor<=(addr_cnt>=TABLE_LEN), rd_valid<=1.
  - addr_cnt<=addr_cnt+1, wrapping modulo 2^ADDR_WIDTH (255 is followed by 0).
  - remaining<=remaining-1.
- Output hold: rd_valid&&rd_ready with no load clears rd_valid. While rd_valid=1 and rd_ready=0, rd_data and rd_oor hold stable.
- Latency: start is sampled at edge k, the first word is loaded at edge k+1, so rd_valid is high in cycle k+1. With rd_ready held at 1 the block sustains one word per cycle.
- Completion: on the edge where the final word handshakes (remaining==0, rd_valid&&rd_ready):
  - go to IDLE; busy=0 and done=1 for one cycle; rd_valid=0.
  - A start in that done cycle is accepted normally (back-to-back bursts).
- start while busy=1 is ignored; no queuing.
- base_addr and burst_len are ignored except on an accepted start.
- Reset mid-burst aborts immediately. The word in flight is dropped, rd_valid=0, and done is not asserted.
- rd_ready while rd_valid=0 has no effect.

Test Plan:
- Reset, then start with base=0, len=4 and rd_ready=1 held -> rd_valid for 4 consecutive cycles starting the cycle after start; rd_data=32,31,30,29; rd_oor=0; done pulses once after the 4th handshake; busy is high for exactly 5 cycles.
- base=30, len=4, rd_ready=1 -> rd_data=2,1,0,0 and rd_oor=0,0,1,1.
- base=254, len=4 -> addresses wrap to 254,255,0,1; rd_data=0,0,32,31; rd_oor=1,1,0,0.
- base=5, len=3 with rd_ready low for 3 cycles on each word -> each word (27,26,25) held stable while stalled; exactly 3 handshakes; start pulses during busy are ignored.
- start with len=0 -> done=1 one cycle later; rd_valid and busy never assert. Then start base=0, len=1 in the done cycle -> rd_data=32.
- Assert resetn low mid-burst (base=0, len=8, after 3 words) -> all outputs 0 immediately; no done. A new burst base=10, len=1 after reset returns 22.

Source files
------------

// File: rtl/rom_burst_reader_if.sv
// rom_burst_reader_if: request and word-stream bus of the burst ROM reader.
// Request side: start, base_addr, burst_len in; busy, done out.
// Stream side: rd_data, rd_oor, rd_valid out; rd_ready in.
// master = controller/consumer view, slave = reader view.
interface rom_burst_reader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [LEN_WIDTH-1:0]  burst_len;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_oor;
    logic                  rd_valid;
    logic                  rd_ready;
    modport master (
        output start, base_addr, burst_len, rd_ready,
        input  busy, done, rd_data, rd_oor, rd_valid
    );
    modport slave (
        input  start, base_addr, burst_len, rd_ready,
        output busy, done, rd_data, rd_oor, rd_valid
    );
endinterface

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: formula-defined ROM streamed out in bursts over valid/ready.
// clk, resetn (async, active low); bus (slave): start/base_addr/burst_len request,
// busy/done status, rd_data/rd_oor/rd_valid stream with rd_ready backpressure.
// Entry a holds INIT_TOP - a for a < TABLE_LEN, FILL_VALUE beyond.
module rom_burst_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TABLE_LEN  = 32,
    parameter int INIT_TOP   = 32,
    parameter int FILL_VALUE = 0,
    parameter int LEN_WIDTH  = 8
) (
    input logic               clk,
    input logic               resetn,
    rom_burst_reader_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [DATA_WIDTH-1:0] data;
    logic                  oor;
    logic                  vld;
    logic                  done;
    logic                  addr_oor;
    logic [DATA_WIDTH-1:0] word;
    logic                  load;
    always_comb begin
        addr_oor = int'(addr_cnt) >= TABLE_LEN;
        word = addr_oor ? DATA_WIDTH'(FILL_VALUE) : DATA_WIDTH'(INIT_TOP - int'(addr_cnt));
        load = state == RUN && remaining != '0 && (!vld || bus.rd_ready);
    end
    assign bus.busy     = state == RUN;
    assign bus.done     = done;
    assign bus.rd_data  = data;
    assign bus.rd_oor   = oor;
    assign bus.rd_valid = vld;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            remaining <= '0;
            data      <= '0;
            oor       <= 1'b0;
            vld       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (bus.start && bus.burst_len != '0) begin
                    state     <= RUN;
                    addr_cnt  <= bus.base_addr;
                    remaining <= bus.burst_len;
                end else if (bus.start) begin
                    done <= 1'b1;
                end
            end else if (load) begin
                data      <= word;
                oor       <= addr_oor;
                vld       <= 1'b1;
                addr_cnt  <= addr_cnt + ADDR_WIDTH'(1);
                remaining <= remaining - LEN_WIDTH'(1);
            end else if (vld && bus.rd_ready) begin
                // Loads continue whenever words remain, so a bare handshake is the last word.
                vld <= 1'b0;
                if (remaining == '0) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: randomized and directed bench for rom_burst_reader with a table model.
module tb_rom_burst_reader;
    logic clk = 1'b0;
    logic resetn = 1'b1;
    int passed = 0;
    int total = 0;
    logic [7:0] got_d[$];
    logic got_o[$];
    int busy_n, done_n, done_t, first_t, hold_err;

    rom_burst_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LEN_WIDTH(8)) bus ();
    rom_burst_reader dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [7:0] f(input int a);
        return (a < 32) ? 8'(32 - a) : 8'd0;
    endfunction

    // Issues one burst and records every handshaken word; entered and left #1 after a rising edge.
    // stall: 0 = ready held high, >0 = that many stalled cycles per word, <0 = random ready.
    task automatic run_burst(input logic [7:0] base, input logic [7:0] len, input int stall, input bit poke);
        int wait_n = 0;
        int t = 0;
        logic pv = 1'b0;
        logic [7:0] pd = 8'd0;
        logic po = 1'b0;
        got_d.delete();
        got_o.delete();
        busy_n = 0; done_n = 0; done_t = -1; first_t = -1; hold_err = 0;
        bus.start = 1'b1; bus.base_addr = base; bus.burst_len = len; bus.rd_ready = (stall == 0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (t < 400 && (done_t < 0 || t < done_t + 3)) begin
            if (pv && (!bus.rd_valid || bus.rd_data !== pd || bus.rd_oor !== po)) hold_err++;
            if (bus.rd_valid && first_t < 0) first_t = t;
            if (stall < 0) bus.rd_ready = 1'($urandom_range(0, 1));
            else if (stall > 0) bus.rd_ready = bus.rd_valid && wait_n >= stall;
            if (bus.rd_valid) wait_n++;
            if (bus.rd_valid && bus.rd_ready) begin
                got_d.push_back(bus.rd_data);
                got_o.push_back(bus.rd_oor);
                wait_n = 0;
            end
            pv = bus.rd_valid && !bus.rd_ready; pd = bus.rd_data; po = bus.rd_oor;
            bus.start = poke && bus.busy;
            if (bus.start) begin
                bus.base_addr = 8'($urandom);
                bus.burst_len = 8'($urandom);
            end
            busy_n += int'(bus.busy);
            if (bus.done) begin
                done_n++;
                if (done_t < 0) done_t = t;
            end
            @(posedge clk); #1;
            t++;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        #2 resetn = 1'b0;
        #1;
        total++; if ({bus.busy, bus.done, bus.rd_valid, bus.rd_oor, bus.rd_data} !== 12'd0) $display("FAIL reset_outputs: got %b expected 0", {bus.busy, bus.done, bus.rd_valid, bus.rd_oor, bus.rd_data}); else passed++;
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        run_burst(8'd0, 8'd4, 0, 1'b0);
        total++; if (got_d.size() !== 4) $display("FAIL basic_count: got %0d expected 4", got_d.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++; if (got_d[i] !== f(i)) $display("FAIL basic_data[%0d]: got %0d expected %0d", i, got_d[i], f(i)); else passed++;
            total++; if (got_o[i] !== 1'b0) $display("FAIL basic_oor[%0d]: got %b expected 0", i, got_o[i]); else passed++;
        end
        total++; if (first_t !== 1) $display("FAIL basic_latency: got %0d expected 1", first_t); else passed++;
        total++; if (busy_n !== 5) $display("FAIL basic_busy_cycles: got %0d expected 5", busy_n); else passed++;
        total++; if (done_n !== 1) $display("FAIL basic_done_count: got %0d expected 1", done_n); else passed++;
        total++; if (done_t !== 5) $display("FAIL basic_done_time: got %0d expected 5", done_t); else passed++;
    endtask

    task automatic test_boundary(input logic [7:0] base, input string name);
        run_burst(base, 8'd4, 0, 1'b0);
        total++; if (got_d.size() !== 4) $display("FAIL %s_count: got %0d expected 4", name, got_d.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            int a = (int'(base) + i) % 256;
            total++; if (got_d[i] !== f(a)) $display("FAIL %s_data[%0d]: got %0d expected %0d", name, i, got_d[i], f(a)); else passed++;
            total++; if (got_o[i] !== (a >= 32)) $display("FAIL %s_oor[%0d]: got %b expected %b", name, i, got_o[i], a >= 32); else passed++;
        end
        total++; if (done_n !== 1) $display("FAIL %s_done_count: got %0d expected 1", name, done_n); else passed++;
    endtask

    task automatic test_stall;
        run_burst(8'd5, 8'd3, 3, 1'b1);
        total++; if (got_d.size() !== 3) $display("FAIL stall_count: got %0d expected 3", got_d.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            total++; if (got_d[i] !== f(5 + i)) $display("FAIL stall_data[%0d]: got %0d expected %0d", i, got_d[i], f(5 + i)); else passed++;
        end
        total++; if (hold_err !== 0) $display("FAIL stall_hold: got %0d unstable cycles expected 0", hold_err); else passed++;
        total++; if (done_n !== 1) $display("FAIL stall_done_count: got %0d expected 1", done_n); else passed++;
        total++; if (busy_n !== 13) $display("FAIL stall_busy_cycles: got %0d expected 13", busy_n); else passed++;
    endtask

    task automatic test_back_to_back;
        bus.start = 1'b1; bus.base_addr = 8'($urandom); bus.burst_len = 8'd0; bus.rd_ready = 1'b0;
        @(posedge clk); #1;
        total++; if ({bus.done, bus.busy, bus.rd_valid} !== 3'b100) $display("FAIL zero_len_done: got %b expected 100", {bus.done, bus.busy, bus.rd_valid}); else passed++;
        bus.base_addr = 8'd0; bus.burst_len = 8'd1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.rd_ready = 1'b1;
        total++; if ({bus.done, bus.busy, bus.rd_valid} !== 3'b010) $display("FAIL b2b_accept: got %b expected 010", {bus.done, bus.busy, bus.rd_valid}); else passed++;
        @(posedge clk); #1;
        total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== f(0)) $display("FAIL b2b_word: got valid %b data %0d expected valid 1 data %0d", bus.rd_valid, bus.rd_data, f(0)); else passed++;
        @(posedge clk); #1;
        total++; if ({bus.done, bus.busy, bus.rd_valid} !== 3'b100) $display("FAIL b2b_done: got %b expected 100", {bus.done, bus.busy, bus.rd_valid}); else passed++;
        @(posedge clk); #1;
        total++; if (bus.done !== 1'b0) $display("FAIL b2b_done_pulse: got %b expected 0", bus.done); else passed++;
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        int dn = 0;
        bus.rd_ready = 1'b1; bus.start = 1'b1; bus.base_addr = 8'd0; bus.burst_len = 8'd8;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 20 && seen < 3; i++) begin
            if (bus.rd_valid) seen++;
            @(posedge clk); #1;
        end
        total++; if (seen !== 3) $display("FAIL abort_words_before: got %0d expected 3", seen); else passed++;
        total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== f(3)) $display("FAIL abort_in_flight: got valid %b data %0d expected valid 1 data %0d", bus.rd_valid, bus.rd_data, f(3)); else passed++;
        resetn = 1'b0;
        #1;
        total++; if ({bus.busy, bus.done, bus.rd_valid, bus.rd_oor, bus.rd_data} !== 12'd0) $display("FAIL abort_outputs: got %b expected 0", {bus.busy, bus.done, bus.rd_valid, bus.rd_oor, bus.rd_data}); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            dn += int'(bus.done);
        end
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dn += int'(bus.done);
            @(posedge clk); #1;
        end
        total++; if (dn !== 0) $display("FAIL abort_no_done: got %0d done cycles expected 0", dn); else passed++;
        run_burst(8'd10, 8'd1, 0, 1'b0);
        total++; if (got_d.size() !== 1 || got_d[0] !== f(10)) $display("FAIL abort_recover: got %0d words first %0d expected 1 word %0d", got_d.size(), got_d[0], f(10)); else passed++;
        total++; if (done_n !== 1) $display("FAIL abort_recover_done: got %0d expected 1", done_n); else passed++;
    endtask

    task automatic test_random;
        for (int b = 0; b < 8; b++) begin
            logic [7:0] base = 8'($urandom);
            int len = $urandom_range(1, 12);
            run_burst(base, 8'(len), -1, 1'($urandom_range(0, 1)));
            total++; if (got_d.size() !== len) $display("FAIL rand%0d_count: got %0d expected %0d", b, got_d.size(), len); else passed++;
            for (int i = 0; i < len && i < got_d.size(); i++) begin
                int a = (int'(base) + i) % 256;
                total++; if (got_d[i] !== f(a) || got_o[i] !== (a >= 32)) $display("FAIL rand%0d_word[%0d]: got %0d/%b expected %0d/%b", b, i, got_d[i], got_o[i], f(a), a >= 32); else passed++;
            end
            total++; if (hold_err !== 0 || done_n !== 1) $display("FAIL rand%0d_protocol: got hold_err %0d done %0d expected 0 and 1", b, hold_err, done_n); else passed++;
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.base_addr = 8'd0; bus.burst_len = 8'd0; bus.rd_ready = 1'b0;
        test_reset();
        test_basic();
        test_boundary(8'd30, "oor");
        test_boundary(8'd254, "wrap");
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
